// File: rtl/kuz_round_ctrl.sv
//------------------------------------------------------------------------------
// kuz_round_ctrl : iterative Kuznyechik encryptor (9 X-S-L rounds + final X).
// Build option   : KUZ_FAST_L_EN chains four R-steps per LIN cycle.
// Revision       : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module kuz_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [3:0]   key_idx_o,
  input  logic [127:0] key_i,
  output logic [127:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XS    = 3'd1,
    S_LIN   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Element 0 is the leftmost byte, so c_SBOX[x] is pi(x).
  localparam logic [0:255][7:0] c_SBOX = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  // Coefficient for byte k (index 15 multiplies a15).
  localparam logic [15:0][7:0] c_LCOEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1,   8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

`ifdef KUZ_FAST_L_EN
  localparam logic [3:0] c_LIN_LAST = 4'd3;
`else
  localparam logic [3:0] c_LIN_LAST = 4'd15;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] s_layer(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = c_SBOX[s[8*k +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] r_step(input logic [127:0] s);
    logic [7:0] l;
    l = 8'h00;
    for (int k = 0; k < 16; k++) l = l ^ gf_mul(s[8*k +: 8], c_LCOEF[k]);
    return {l, s[127:8]};
  endfunction

  state_t       r_state;
  logic [127:0] r_st;
  logic [3:0]   r_rnd;
  logic [3:0]   r_stp;

  logic [127:0] w_xs;
  logic [127:0] w_lin;
  logic [127:0] w_final;

  assign w_xs    = s_layer(r_st ^ key_i);
  assign w_final = r_st ^ key_i;
`ifdef KUZ_FAST_L_EN
  assign w_lin   = r_step(r_step(r_step(r_step(r_st))));
`else
  assign w_lin   = r_step(r_st);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_st      <= '0;
      r_rnd     <= '0;
      r_stp     <= '0;
      key_idx_o <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      ready_o   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_st      <= data_i;
            r_rnd     <= 4'd0;
            key_idx_o <= 4'd0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b1;
            r_state   <= S_XS;
          end
        end
        S_XS: begin
          r_st      <= w_xs;
          r_stp     <= 4'd0;
          key_idx_o <= 4'd0;
          r_state   <= S_LIN;
        end
        S_LIN: begin
          r_st <= w_lin;
          if (r_stp == c_LIN_LAST) begin
            r_stp <= 4'd0;
            r_rnd <= r_rnd + 4'd1;
            // key index is registered one cycle ahead so it lines up with XS/FINAL
            if (r_rnd == 4'd8) begin
              key_idx_o <= 4'd9;
              r_state   <= S_FINAL;
            end else begin
              key_idx_o <= r_rnd + 4'd1;
              r_state   <= S_XS;
            end
          end else begin
            r_stp <= r_stp + 4'd1;
          end
        end
        S_FINAL: begin
          data_o    <= w_final;
          valid_o   <= 1'b1;
          key_idx_o <= 4'd0;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kuz_round_ctrl.sv
//------------------------------------------------------------------------------
// tb_kuz_round_ctrl : scoreboard bench for kuz_round_ctrl with GOST vectors.
// Revision          : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_kuz_round_ctrl;

`ifdef KUZ_FAST_L_EN
  localparam int RL   = 5;
  localparam int LINC = 4;
`else
  localparam int RL   = 17;
  localparam int LINC = 16;
`endif
  localparam int LAT  = 9 * RL + 1;
  localparam int THRU = LAT + 2;

  localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [3:0]   key_idx_o;
  logic [127:0] key_i;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic         busy_o;

  logic [127:0] kt [16];
  logic         zero_keys = 1'b0;
  assign key_i = zero_keys ? '0 : kt[key_idx_o];

  kuz_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .key_idx_o (key_idx_o),
    .key_i     (key_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected ciphertext and acceptance cycle per block
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic         prev_v = 1'b0;

  always @(negedge clk) begin
    if (valid_o && !prev_v) begin
      chkint("output_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        chk128("ciphertext", data_o, exp_q[0]);
        chkint("latency", cyc - acc_q[0], LAT);
        exp_q.delete(0);
        acc_q.delete(0);
      end
    end
    prev_v <= valid_o;
  end

  // Key index trace relative to the most recent acceptance
  int kacc  = 0;
  bit ktrack = 1'b0;

  always @(negedge clk) begin
    if (ktrack && !rst && cyc >= kacc && (cyc - kacc) <= 9 * RL) begin
      if (((cyc - kacc) % RL) == 0)
        chkint("key_idx_xs", int'(key_idx_o), (cyc - kacc) / RL);
      else
        chkint("key_idx_lin", int'(key_idx_o), 0);
    end
  end

  int last_acc = 0;

  task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    data_i  = d;
    valid_i = 1'b1;
    while (!ready_o && n < 2 * THRU) begin
      @(negedge clk);
      n++;
    end
    chkint("accept_ready", int'(ready_o), 1);
    last_acc = cyc + 1;
    if (push) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
    end
    kacc   = cyc + 1;
    ktrack = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o || busy_o) && n < 3 * THRU) begin
      @(negedge clk);
      n++;
    end
    chkint("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    ktrack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
  endtask

  initial begin
    int a1;
    int n;
    kt[0] = 128'h8899aabbccddeeff0011223344556677;
    kt[1] = 128'hfedcba98765432100123456789abcdef;
    kt[2] = 128'hdb31485315694343228d6aef8cc78c44;
    kt[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
    kt[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
    kt[5] = 128'hbd079435165c6432b532e82834da581b;
    kt[6] = 128'h51e640757e8745de705727265a0098b1;
    kt[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
    kt[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
    kt[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
    for (int i = 10; i < 16; i++) kt[i] = '0;

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk128("rst_data_o", data_o, '0);
    chkint("rst_valid_o", int'(valid_o), 0);
    chkint("rst_busy_o", int'(busy_o), 0);
    chkint("rst_key_idx", int'(key_idx_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chkint("rst_ready_o", int'(ready_o), 1);

    // GOST A.2.4 single block
    send(PT, CT, 1'b1);
    wait_drain();

    // Internal datapath probes with all-zero keys
    zero_keys = 1'b1;
    send(128'hffeeddccbbaa99881122334455667700, '0, 1'b0);
    wait_cyc(last_acc + 1);
    chk128("s_layer", dut.r_st, 128'hb66cd8887d38e8d77765aeea0c9a7efc);
    do_reset();

    send(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a52da5, '0, 1'b0);
    wait_cyc(last_acc + 1);
    chk128("s_to_r_input", dut.r_st, 128'h00000000000000000000000000000100);
`ifndef KUZ_FAST_L_EN
    wait_cyc(last_acc + 2);
    chk128("r_step", dut.r_st, 128'h94000000000000000000000000000001);
`endif
    do_reset();

    send(128'hacba95a5a5a5a5a5a5a5a5a5a5a5a5a5, '0, 1'b0);
    wait_cyc(last_acc + 1 + LINC);
    chk128("l_full", dut.r_st, 128'hd456584dd0e3e84cc3166e4b7fa2890d);
    do_reset();
    zero_keys = 1'b0;

    // Backpressure: hold output for 20 cycles while poking valid_i
    ready_i = 1'b0;
    send(PT, CT, 1'b1);
    n = 0;
    while (!valid_o && n < 2 * THRU) begin
      @(negedge clk);
      n++;
    end
    chkint("bp_valid_rise", int'(valid_o), 1);
    for (int i = 0; i < 20; i++) begin
      valid_i = i[0];
      data_i  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk128("bp_data_hold", data_o, CT);
      chkint("bp_valid_hold", int'(valid_o), 1);
      chkint("bp_ready_low", int'(ready_o), 0);
    end
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    @(negedge clk);
    chkint("bp_release_valid", int'(valid_o), 0);
    chkint("bp_release_ready", int'(ready_o), 1);
    chkint("bp_release_busy", int'(busy_o), 0);

    // Asynchronous reset during the fourth round's LIN phase
    send(PT, CT, 1'b1);
    wait_cyc(last_acc + 3 * RL + LINC / 2 + 1);
    ktrack = 1'b0;
    rst = 1'b1;
    #1;
    chk128("mid_rst_data_o", data_o, '0);
    chkint("mid_rst_valid_o", int'(valid_o), 0);
    chkint("mid_rst_busy_o", int'(busy_o), 0);
    chkint("mid_rst_key_idx", int'(key_idx_o), 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chkint("mid_rst_ready_o", int'(ready_o), 1);
    send(PT, CT, 1'b1);
    wait_drain();

    // Back-to-back with ready_i tied high
    ready_i = 1'b1;
    send(PT, CT, 1'b1);
    a1 = last_acc;
    send(PT, CT, 1'b1);
    chkint("b2b_spacing", last_acc - a1, THRU);
    wait_drain();
    ktrack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kuz_round_ctrl.md
# kuz_round_ctrl

Iterative round sequencer for the Grasspopper (GOST R 34.12-2015 "Kuznyechik") 128-bit encryptor. It accepts one plaintext block per transaction and applies nine X-S-L rounds plus a final X, fetching round keys from an external key store by index. It instantiates the byte-wise S-box substitution stage combinationally and implements the linear transform L as iterated R-steps. It sits between the block input FIFO and the output formatter.

## Interface
- No parameters (block width fixed at 128 bits, 16 bytes; byte 15 = bits [127:120]).
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  128  plaintext block.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block can accept input; high only in IDLE.
- key_idx_o  output  4  round-key index, 0..9 (K1..K10).
- key_i  input  128  round key for key_idx_o; combinational from key store, same cycle.
- data_o  output  128  ciphertext; stable while valid_o high.
- valid_o  output  1  ciphertext valid.
- ready_i  input  1  downstream accepts data_o.
- busy_o  output  1  high in any state except IDLE.

## Operation
- State register st[127:0], round counter rnd (0..9), step counter stp (0..15).
- FSM states:
  - IDLE: ready_o=1. On valid_i: st←data_i, rnd←0, go XS.
  - XS: key_idx_o=rnd. st←S(st ^ key_i), stp←0, go LIN.
  - LIN: one R-step per cycle, st←R(st), stp++. At stp=15: rnd++; go FINAL if rnd was 8, else XS.
  - FINAL: key_idx_o=9. data_o←st ^ key_i, go DONE.
  - DONE: valid_o=1. On ready_i: valid_o←0, go IDLE.
- R(a15..a0) = l(a15..a0) ‖ a15..a1, i.e. shift right one byte with new byte 15 = l.
- l = 148·a15 ⊕ 32·a14 ⊕ 133·a13 ⊕ 16·a12 ⊕ 194·a11 ⊕ 192·a10 ⊕ 1·a9 ⊕ 251·a8 ⊕ 1·a7 ⊕ 192·a6 ⊕ 194·a5 ⊕ 16·a4 ⊕ 133·a3 ⊕ 32·a2 ⊕ 148·a1 ⊕ 1·a0.
- Multiplication in GF(2^8) mod x^8+x^7+x^6+x+1 (0x1C3), constant multipliers.
- key_idx_o = 0 in IDLE, LIN and DONE.
- ready_o is low in DONE: no new block is accepted in the same cycle as output acceptance.
- valid_i while busy is ignored; data_i is not sampled.

## Timing
- Reset (async, any state): FSM→IDLE; st, data_o = 0; rnd, stp, key_idx_o = 0; valid_o=0, busy_o=0, ready_o=1 after release.
- Reset mid-operation discards the block; no partial output appears.
- Acceptance edge = E0. Each round = 17 cycles (1 XS + 16 LIN). FINAL = 1 cycle.
- valid_o rises after edge E0+154. Base latency 154 cycles.
- data_o/valid_o are registered and hold until the first cycle with ready_i=1 while in DONE. IDLE follows on the next edge.
- Back-to-back throughput: 1 block per 156 cycles with ready_i tied high.
- key_i must be valid in the same cycle as key_idx_o. The key store is combinational with no wait states.

## Configuration
- KUZ_FAST_L_EN defined: LIN performs four chained R-steps per cycle. stp counts 0..3, so L takes 4 cycles, a round takes 5, and latency is 9·5+1 = 46 cycles.
- Undefined: one R-step per cycle, 154-cycle latency.
- Results are bit-identical in both builds.

## Test plan
- GOST A.2.4 vector: round keys K1..K10 from key 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef, data_i=1122334455667700ffeeddccbbaa9988 → data_o=7f679d90bebc24305a468d42b9d4edcd, valid_o exactly 154 cycles (46 with KUZ_FAST_L_EN) after acceptance.
- Internal checks, all keys zero, probe st:
  - After XS: S(ffeeddccbbaa99881122334455667700) = b66cd8887d38e8d77765aeea0c9a7efc.
  - After one R-step: R(00…0100) = 94000000000000000000000000000001.
  - After full L: L(64a59400000000000000000000000000) = d456584dd0e3e84cc3166e4b7fa2890d.
- Backpressure: hold ready_i=0 for 20 cycles after valid_o rises → data_o stable, ready_o=0, valid_i pulses ignored. Release → one transfer, IDLE next cycle.
- Reset asserted in round 4 LIN → outputs zero immediately (asynchronous). After release, the A.2.4 vector re-run gives the correct ciphertext.
- Two back-to-back blocks with ready_i=1 → both ciphertexts correct, second accepted exactly 156 cycles after the first, and key_idx_o sequence 0..8 then 9 per block.
